mac_seq_ctrl: RTL and testbench

Sequencer for the 256-bit MAC datapath; runs one dot-product job of i_len 256-bit chunks through a combinational mac instance.
- Accepts a job command, pulls operand chunks over a valid/ready stream and drives the mac inputs from a register stage.
- Feeds the mac result back as the next partial sum.
- Presents the final 24-bit result on a valid/ready output.
- Sits between the operand buffers and the downstream result writer.

---
 rtl/mac_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for the 256-bit MAC datapath.
// Accepts one dot-product job, streams i_len operand chunks into a combinational
// mac through a register stage, feeds the mac result back as the partial sum and
// presents the final 24-bit sum on a valid/ready output.
// Optional build macro: MAC_SEQ_PERF_EN adds o_perf_stall, a saturating count of
// RUN cycles that saw no operand handshake.
module mac_seq_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [255:0]     i_a,
    input  logic [255:0]     i_b,
    input  logic [7:0]       i_scale_a,
    input  logic [7:0]       i_scale_b,
    output logic [1:0]       o_mac_mode,
    output logic [23:0]      o_mac_psum,
    output logic [255:0]     o_mac_a,
    output logic [255:0]     o_mac_b,
    output logic [7:0]       o_mac_scale_a,
    output logic [7:0]       o_mac_scale_b,
    input  logic [23:0]      i_mac_result,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [23:0]      o_out_data
`ifdef MAC_SEQ_PERF_EN
    ,
    output logic [15:0]      o_perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       mode_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] count_reg;
    logic [LEN_W-1:0] count_inc;
    logic [23:0]      psum_reg;
    logic [255:0]     a_reg, b_reg;
    logic [7:0]       scale_a_reg, scale_b_reg;
    logic             op_vld_reg;
    logic             start_ok;
    logic             in_fire;
    logic             last_fire;

    // Mode 3 is reserved and a zero-length job has nothing to do; both are dropped.
    assign start_ok  = i_start && (i_len != '0) && (i_mode != 2'd3);
    assign in_fire   = i_in_valid && (state_reg == RUN);
    assign count_inc = count_reg + 1'b1;
    assign last_fire = in_fire && (count_inc == len_reg);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok)    state_next = RUN;
            RUN:     if (last_fire)   state_next = FLUSH;
            FLUSH:                    state_next = DONE;
            DONE:    if (i_out_ready) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Handshake/status outputs decoded from the current state
    always_comb begin
        o_busy      = (state_reg != IDLE);
        o_in_ready  = (state_reg == RUN);
        o_out_valid = (state_reg == DONE);
    end

    // Job registers, operand stage and partial-sum feedback
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_reg    <= '0;
            len_reg     <= '0;
            count_reg   <= '0;
            psum_reg    <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            scale_a_reg <= '0;
            scale_b_reg <= '0;
            op_vld_reg  <= 1'b0;
        end else begin
            // op_vld marks that the operand stage holds a chunk the mac is working on now.
            op_vld_reg <= in_fire;
            if (state_reg == IDLE && start_ok) begin
                mode_reg  <= i_mode;
                len_reg   <= i_len;
                count_reg <= '0;
                psum_reg  <= '0;
            end
            if (in_fire) begin
                a_reg       <= i_a;
                b_reg       <= i_b;
                scale_a_reg <= i_scale_a;
                scale_b_reg <= i_scale_b;
                count_reg   <= count_inc;
            end
            // op_vld is never set in IDLE, so this cannot collide with the psum clear above.
            if (op_vld_reg) begin
                psum_reg <= i_mac_result;
            end
        end
    end

    assign o_mac_mode    = mode_reg;
    assign o_mac_psum    = psum_reg;
    assign o_mac_scale_a = scale_a_reg;
    assign o_mac_scale_b = scale_b_reg;
    assign o_out_data    = psum_reg;

    // Operand lanes are held at zero while the stage is empty so the mac array does not toggle.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_lane
            assign o_mac_a[gi*8 +: 8] = op_vld_reg ? a_reg[gi*8 +: 8] : 8'h00;
            assign o_mac_b[gi*8 +: 8] = op_vld_reg ? b_reg[gi*8 +: 8] : 8'h00;
        end
    endgenerate

`ifdef MAC_SEQ_PERF_EN
    logic [15:0] perf_stall_reg;

    // Saturating count of RUN cycles with no operand handshake; cleared by each accepted job.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            perf_stall_reg <= '0;
        end else if (state_reg == IDLE && start_ok) begin
            perf_stall_reg <= '0;
        end else if (state_reg == RUN && !i_in_valid && perf_stall_reg != 16'hFFFF) begin
            perf_stall_reg <= perf_stall_reg + 16'd1;
        end
    end

    assign o_perf_stall = perf_stall_reg;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: a behavioural mac answers the DUT's mac port, and each
// job's expected result is the wrapped sum of per-chunk dot-product terms.
// Build with MAC_SEQ_PERF_EN to also check the stall counter.
module tb_mac_seq_ctrl;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [255:0]     a = '0, b = '0;
    logic [7:0]       scale_a = '0, scale_b = '0;
    logic [1:0]       mac_mode;
    logic [23:0]      mac_psum;
    logic [255:0]     mac_a, mac_b;
    logic [7:0]       mac_scale_a, mac_scale_b;
    logic [23:0]      mac_result;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [23:0]      out_data;
`ifdef MAC_SEQ_PERF_EN
    logic [15:0]      perf_stall;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [255:0] ca[$], cb[$];
    logic [7:0]   csa[$], csb[$];

    mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_mode       (mode),
        .i_len        (len),
        .o_busy       (busy),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_a          (a),
        .i_b          (b),
        .i_scale_a    (scale_a),
        .i_scale_b    (scale_b),
        .o_mac_mode   (mac_mode),
        .o_mac_psum   (mac_psum),
        .o_mac_a      (mac_a),
        .o_mac_b      (mac_b),
        .o_mac_scale_a(mac_scale_a),
        .o_mac_scale_b(mac_scale_b),
        .i_mac_result (mac_result),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data)
`ifdef MAC_SEQ_PERF_EN
        ,
        .o_perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Dot product of one chunk: signed int8 or int4 lanes, VSQ scales applied as (dot*sa*sb)>>>8.
    function automatic int chunk_term(input logic [1:0] m, input logic [255:0] x, input logic [255:0] y,
                                      input logic [7:0] sa, input logic [7:0] sb);
        int acc;
        int sai;
        int sbi;
        acc = 0;
        sai = sa;
        sbi = sb;
        if (m == 2'd0) begin
            for (int i = 0; i < 32; i++) acc += $signed(x[i*8 +: 8]) * $signed(y[i*8 +: 8]);
        end else begin
            for (int i = 0; i < 64; i++) acc += $signed(x[i*4 +: 4]) * $signed(y[i*4 +: 4]);
            if (m == 2'd2) acc = (acc * sai * sbi) >>> 8;
        end
        return acc;
    endfunction

    // Behavioural combinational mac
    always_comb begin
        int t;
        t = chunk_term(mac_mode, mac_a, mac_b, mac_scale_a, mac_scale_b);
        mac_result = mac_psum + t[23:0];
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [23:0] model_result(input logic [1:0] m);
        logic [23:0] s;
        int t;
        s = '0;
        for (int i = 0; i < ca.size(); i++) begin
            t = chunk_term(m, ca[i], cb[i], csa[i], csb[i]);
            s = s + t[23:0];
        end
        return s;
    endfunction

    // Fill the chunk queues with one chunk pattern repeated n times
    task automatic fill_const(input int n, input logic [255:0] x, input logic [255:0] y,
                              input logic [7:0] sa, input logic [7:0] sb);
        ca.delete(); cb.delete(); csa.delete(); csb.delete();
        for (int i = 0; i < n; i++) begin
            ca.push_back(x); cb.push_back(y); csa.push_back(sa); csb.push_back(sb);
        end
    endtask

    task automatic fill_rand(input int n);
        ca.delete(); cb.delete(); csa.delete(); csb.delete();
        for (int i = 0; i < n; i++) begin
            ca.push_back(rand256()); cb.push_back(rand256());
            csa.push_back(8'($urandom)); csb.push_back(8'($urandom));
        end
    endtask

    // pattern: 0 valid every cycle, 1 one idle cycle after each accepted chunk, 2 random valid.
    task automatic run_job(input logic [1:0] m, input int pattern, input int stall, input bit mid_start);
        int n;
        int idx;
        int cyc;
        int stalls;
        bit prev_fire;
        bit drive;
        logic [23:0] exp;
        n = ca.size();
        exp = model_result(m);
        @(negedge clk);
        start = 1'b1; mode = m; len = LEN_W'(n);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        idx = 0; cyc = 0; stalls = 0; prev_fire = 1'b0;
        while (idx < n) begin
            check("in_ready_run", in_ready, 1'b1);
            check("mac_mode", mac_mode, m);
            if (prev_fire) check("mac_a_stage", mac_a, ca[idx-1]);
            else           check("mac_a_gated", mac_a, 256'd0);
            case (pattern)
                0:       drive = 1'b1;
                1:       drive = !prev_fire;
                default: drive = (cyc > 40) ? 1'b1 : 1'($urandom_range(1, 0));
            endcase
            in_valid = drive;
            a = drive ? ca[idx] : rand256();
            b = drive ? cb[idx] : rand256();
            scale_a = drive ? csa[idx] : 8'($urandom);
            scale_b = drive ? csb[idx] : 8'($urandom);
            start = mid_start && (idx == 1);
            mode  = start ? 2'd1 : m;
            len   = start ? LEN_W'(n + 3) : LEN_W'(n);
            @(negedge clk);
            if (drive) idx++; else stalls++;
            prev_fire = drive;
            cyc++;
            if (cyc > 300) begin
                check("run_timeout", 1'b1, 1'b0);
                break;
            end
        end
        in_valid = 1'b0; start = 1'b0;
        check("flush_no_valid", out_valid, 1'b0);
        check("flush_not_ready", in_ready, 1'b0);
        @(negedge clk);
        check("done_valid", out_valid, 1'b1);
        check("done_data", out_data, exp);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, exp);
        end
`ifdef MAC_SEQ_PERF_EN
        check("perf_stall", perf_stall, 16'(stalls));
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_valid", out_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
        $display("job mode=%0d len=%0d stalls=%0d result=%h expected=%h", m, n, stalls, out_data, exp);
    endtask

    logic [255:0] v01, v02, v11, v_f;

    initial begin
        v01 = {32{8'h01}};
        v02 = {32{8'h02}};
        v11 = {64{4'h1}};
        v_f = {64{4'hF}};

        // Reset state
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 24'd0);
        check("rst_mac_psum", mac_psum, 24'd0);
        check("rst_mac_a", mac_a, 256'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed jobs
        fill_const(2, v01, v02, 8'd0, 8'd0);
        run_job(2'd0, 0, 0, 1'b0);
        check("int8_len2_value", out_data, 24'h000080);
        fill_const(1, v11, v_f, 8'd0, 8'd0);
        run_job(2'd1, 0, 0, 1'b0);
        check("int4_value", out_data, 24'hFFFFC0);
        fill_const(1, v11, v11, 8'd128, 8'd128);
        run_job(2'd2, 0, 0, 1'b0);
        check("vsq_value", out_data, 24'h001000);
        fill_const(3, v01, v02, 8'd0, 8'd0);
        run_job(2'd0, 1, 4, 1'b0);
        check("int8_len3_gaps", out_data, 24'd192);

        // Ignored starts: mid-job restart, zero length, reserved mode
        fill_const(2, v01, v02, 8'd0, 8'd0);
        run_job(2'd0, 0, 1, 1'b1);
        check("mid_start_value", out_data, 24'h000080);
        @(negedge clk);
        start = 1'b1; mode = 2'd0; len = '0;
        @(negedge clk);
        start = 1'b1; mode = 2'd3; len = LEN_W'(2);
        @(negedge clk);
        start = 1'b0;
        check("len0_mode3_busy", busy, 1'b0);
        check("len0_mode3_ready", in_ready, 1'b0);

        // Reset after the first of four chunks
        @(negedge clk);
        start = 1'b1; mode = 2'd0; len = LEN_W'(4);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; a = v01; b = v02;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_psum", mac_psum, 24'd0);
        check("midrst_mac_a", mac_a, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_valid", out_valid, 1'b0);
        end
        fill_const(2, v01, v02, 8'd0, 8'd0);
        run_job(2'd0, 0, 0, 1'b0);
        check("after_rst_value", out_data, 24'h000080);

        // Randomized jobs
        for (int j = 0; j < 12; j++) begin
            fill_rand($urandom_range(6, 1));
            run_job(2'($urandom_range(2, 0)), 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
